stim_frame_tx: RTL
==================

# stim_frame_tx

Downstream consumer of the parameter double-buffer. It paces stimulation frames with a programmable period and raises TX_START so the upstream receiver advances its active buffer. It then snapshots the active parameter set and shifts it MSB-first, with an even-parity bit, to the stimulator ASIC over a three-wire serial link (SCLK/SDATA/SLOAD). All logic runs in the CLK domain.

## Interface
- CLK_DIV, 4: CLK cycles per SCLK half-period (≥1).
- FRAME_PERIOD, 1000: CLK cycles between frame requests (≥2).
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  reset, synchronous, active-low.
- ENABLE  in  1  allows frame requests; sampled every cycle.
- MODE, BIAS_SEL  in  1 each  active parameter fields from upstream.
- BIAS_AMP  in  7, ADDR  in  5, AMP0..AMP3  in  8 each  active parameter fields.
- TX_START  out  1  buffer-advance request to upstream, 4-cycle pulse.
- SCLK  out  1  serial clock, idle low.
- SDATA  out  1  serial data; changes while SCLK is low, sampled by the ASIC on SCLK rise.
- SLOAD  out  1  latch strobe after the last bit.
- BUSY  out  1  high in any state other than IDLE.
- OVERRUN  out  1  sticky: a frame request arrived while not IDLE.
- FRAME_CNT  out  16  completed frames, wraps 65535→0.

## Operation
- Payload: 46 bits, in order {MODE, ADDR, BIAS_SEL, BIAS_AMP, AMP0, AMP1, AMP2, AMP3}. Bit 46 is parity = XOR of the payload, so the total number of ones is even. 47 bits are sent, MODE first, parity last.
- Period counter:
  - Cleared to 0 while ENABLE=0.
  - Increments while ENABLE=1.
  - At FRAME_PERIOD-1 it wraps to 0 and issues a request.
  - The first request occurs FRAME_PERIOD cycles after ENABLE is first sampled high.
- FSM states:
  - IDLE: on a request, go to START. A request arriving in any other state is dropped and sets OVERRUN.
  - START (4 cycles, T0..T3): TX_START=1. At the end of T2 the 46-bit payload and parity are captured into a shift register. Go to SHIFT after T3.
  - SHIFT: 47 bits. Each bit has SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles. SDATA updates on entry to each low half. After the 47th high half, go to LOAD.
  - LOAD (CLK_DIV cycles): SLOAD=1, SCLK=0, SDATA=0. On exit, FRAME_CNT increments and the FSM returns to IDLE.
- Inputs changed after the T2 capture do not affect the frame in flight.
- ENABLE=0 mid-frame: the current frame completes normally, including SLOAD and the count; no further requests are issued.
- OVERRUN clears only on reset or while ENABLE=0.

## Timing
- Reset values (the cycle after an RST=0 edge, including mid-frame): TX_START=0, SCLK=0, SDATA=0, SLOAD=0, BUSY=0, OVERRUN=0, FRAME_CNT=0, FSM in IDLE, period counter=0.
- TX_START is registered. Upstream edge-detects it, so its outputs are valid from T1; the T2 capture gives one cycle of margin.
- First SDATA bit (MODE) is valid from the cycle after T3, with SCLK low.
- Frame duration from TX_START rise to the cycle after SLOAD falls: 4 + 47·2·CLK_DIV + CLK_DIV cycles. For CLK_DIV=4 this is 384.
- FRAME_PERIOD below the frame duration causes a dropped request at every frame, sets OVERRUN, and no frames are lost mid-shift.
- Request and IDLE entry in the same cycle: the request is accepted (IDLE is evaluated after LOAD exit).

## Test plan
- Reset: hold RST=0 for 5 cycles -> all outputs 0; then ENABLE=1 with FRAME_PERIOD=200 -> first TX_START rise exactly 200 cycles after ENABLE is first sampled high.
- Single frame (CLK_DIV=2): MODE=1, ADDR=0x15, BIAS_SEL=0, BIAS_AMP=0x40, AMP0..3=0x12,0x34,0x56,0x78 -> bits captured on SCLK rise are 1_10101_0_1000000_00010010_00110100_01010110_01111000 then parity 0; one SLOAD pulse of 2 cycles; FRAME_CNT=1.
- Snapshot: change AMP0 to 0xFF at T3 and again mid-shift -> serialized AMP0 is still 0x12; the next frame carries 0xFF.
- Overrun (CLK_DIV=2, FRAME_PERIOD=50): run 1000 cycles -> OVERRUN=1; TX_START pulses never overlap BUSY-high frames; each frame carries 47 bits.
- ENABLE dropped at bit 10 -> the frame finishes, SLOAD pulses, FRAME_CNT increments by 1, no TX_START for the next 2·FRAME_PERIOD cycles, OVERRUN=0.
- RST=0 at bit 20 -> next cycle SCLK=0, SDATA=0, BUSY=0, FRAME_CNT=0, no SLOAD issued.

Source files
------------

// File: rtl/stim_frame_tx.sv
// stim_frame_tx: paces stimulation frames, requests a parameter-buffer advance
// via TX_START, snapshots the active parameter set and shifts it (plus an
// even-parity bit) MSB-first to the stimulator ASIC over SCLK/SDATA/SLOAD.
module stim_frame_tx #(
  parameter int CLK_DIV      = 4,
  parameter int FRAME_PERIOD = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        MODE,
  input  logic        BIAS_SEL,
  input  logic [6:0]  BIAS_AMP,
  input  logic [4:0]  ADDR,
  input  logic [7:0]  AMP0,
  input  logic [7:0]  AMP1,
  input  logic [7:0]  AMP2,
  input  logic [7:0]  AMP3,
  output logic        TX_START,
  output logic        SCLK,
  output logic        SDATA,
  output logic        SLOAD,
  output logic        BUSY,
  output logic        OVERRUN,
  output logic [15:0] FRAME_CNT
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PER_W = $clog2(FRAME_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(FRAME_PERIOD - 1);
  localparam logic [5:0]       BIT_LAST = 6'd46;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SHIFT = 2'd2,
    S_LOAD  = 2'd3
  } state_t;

  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic even_parity(input logic [45:0] data);
    return ^data;
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         tcnt_q, tcnt_d;      // START cycle index T0..T3
  logic [DIV_W-1:0]   div_q, div_d;        // CLK cycles within a half-period
  logic               phase_q, phase_d;    // 0 = SCLK low half, 1 = high half
  logic [5:0]         bit_q, bit_d;        // bit index 0..46 within the frame
  logic [46:0]        shreg_q, shreg_d;    // frame snapshot, MSB goes out first
  logic [15:0]        fcnt_q, fcnt_d;
  logic               ovr_q, ovr_d;
  logic [PER_W-1:0]   per_q;
  logic               req_q;
  logic               req_s;
  logic               accept_s;
  logic [45:0]        payload_s;

  logic tx_start_q, sclk_q, sdata_q, sload_q, busy_q;

  assign payload_s = {MODE, ADDR, BIAS_SEL, BIAS_AMP, AMP0, AMP1, AMP2, AMP3};
  // A request latched just before ENABLE fell is discarded.
  assign req_s     = req_q & ENABLE;

  // Frame pacing: count while enabled, emit a one-cycle request on wrap.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      per_q <= '0;
      req_q <= 1'b0;
    end else if (ENABLE) begin
      if (per_q == PER_LAST) begin
        per_q <= '0;
        req_q <= 1'b1;
      end else begin
        per_q <= per_q + PER_W'(1);
        req_q <= 1'b0;
      end
    end else begin
      per_q <= '0;
      req_q <= 1'b0;
    end
  end

  // Next-state logic for the frame FSM, its counters, shift register and flags.
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    div_d    = div_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    fcnt_d   = fcnt_q;
    accept_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        accept_s = 1'b1;
        if (req_s) begin
          state_d = S_START;
          tcnt_d  = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        // Upstream outputs are settled from T1; capture at the end of T2.
        if (tcnt_q == 2'd2) begin
          shreg_d = {payload_s, even_parity(payload_s)};
        end else begin
          shreg_d = shreg_q;
        end
        if (tcnt_q == 2'd3) begin
          state_d = S_SHIFT;
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = 6'd0;
        end else begin
          tcnt_d  = tcnt_q + 2'd1;
        end
      end

      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_q == BIT_LAST) begin
            state_d = S_LOAD;
            phase_d = 1'b0;
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q + 6'd1;
            shreg_d = {shreg_q[45:0], 1'b0};
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_LOAD: begin
        if (div_q == DIV_LAST) begin
          // Last LOAD cycle behaves as IDLE: a coincident request is taken.
          accept_s = 1'b1;
          div_d    = '0;
          fcnt_d   = fcnt_q + 16'd1;
          if (req_s) begin
            state_d = S_START;
            tcnt_d  = 2'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!ENABLE) begin
      ovr_d = 1'b0;
    end else if (req_s && !accept_s) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // FSM and datapath state registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      tcnt_q  <= 2'd0;
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= 6'd0;
      shreg_q <= 47'd0;
      fcnt_q  <= 16'd0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      fcnt_q  <= fcnt_d;
      ovr_q   <= ovr_d;
    end
  end

  // Registered outputs decoded from the next state so they align with state_q.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      tx_start_q <= 1'b0;
      sclk_q     <= 1'b0;
      sdata_q    <= 1'b0;
      sload_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_start_q <= (state_d == S_START);
      sclk_q     <= (state_d == S_SHIFT) && phase_d;
      sdata_q    <= (state_d == S_SHIFT) && shreg_d[46];
      sload_q    <= (state_d == S_LOAD);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign TX_START  = tx_start_q;
  assign SCLK      = sclk_q;
  assign SDATA     = sdata_q;
  assign SLOAD     = sload_q;
  assign BUSY      = busy_q;
  assign OVERRUN   = ovr_q;
  assign FRAME_CNT = fcnt_q;

endmodule
